// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with big-endian load alignment, driving the register-file write port.
// Optional WB-stage forwarding compare is enabled by defining WB_BYPASS_EN.
module mem_wb_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          in_regwrite,
  input  logic          in_memtoreg,
  input  logic [AW-1:0] in_rd,
  input  logic [DW-1:0] in_alu_result,
  input  logic [DW-1:0] in_mem_data,
  input  logic [2:0]    in_load_type,
`ifdef WB_BYPASS_EN
  input  logic [AW-1:0] byp_a1,
  input  logic [AW-1:0] byp_a2,
  output logic          byp_hit1,
  output logic          byp_hit2,
  output logic [DW-1:0] byp_data,
`endif
  output logic [AW-1:0] wb_a3,
  output logic [DW-1:0] wb_wr,
  output logic          wb_wrenable,
  output logic          wb_valid
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  // Byte 0 of the word is bits [31:24]; undefined load types fall back to a full word.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  ltype);
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half   = off[1] ? word[15:0] : word[31:16];
    case (off)
      2'd0:    byte_v = word[31:24];
      2'd1:    byte_v = word[23:16];
      2'd2:    byte_v = word[15:8];
      2'd3:    byte_v = word[7:0];
      default: byte_v = word[31:24];
    endcase
    case (ltype)
      LT_LW:   res = word;
      LT_LH:   res = {{16{half[15]}}, half};
      LT_LHU:  res = {16'h0000, half};
      LT_LB:   res = {{24{byte_v[7]}}, byte_v};
      LT_LBU:  res = {24'h000000, byte_v};
      default: res = word;
    endcase
    return res;
  endfunction

  logic          valid_q, valid_d;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wr_q, wr_d;
  logic [DW-1:0] load_val_s;

  assign load_val_s = align_load(in_mem_data, in_alu_result[1:0], in_load_type);

  // Next-state selection: flush beats stall, stall beats capture.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    a3_d       = a3_q;
    wr_d       = wr_q;
    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      a3_d       = {AW{1'b0}};
      wr_d       = {DW{1'b0}};
    end else if (stall) begin
      valid_d    = valid_q;
      regwrite_d = regwrite_q;
      a3_d       = a3_q;
      wr_d       = wr_q;
    end else begin
      valid_d    = in_valid;
      regwrite_d = in_regwrite;
      a3_d       = in_rd;
      wr_d       = in_memtoreg ? load_val_s : in_alu_result;
    end
  end

  // WB pipeline register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      a3_q       <= {AW{1'b0}};
      wr_q       <= {DW{1'b0}};
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      a3_q       <= a3_d;
      wr_q       <= wr_d;
    end
  end

  assign wb_valid    = valid_q;
  assign wb_a3       = a3_q;
  assign wb_wr       = wr_q;
  // $0 is hardwired zero, so its write is never enabled even though data still flows.
  assign wb_wrenable = valid_q & regwrite_q & (a3_q != {AW{1'b0}});

`ifdef WB_BYPASS_EN
  assign byp_hit1 = wb_wrenable & (byp_a1 == a3_q);
  assign byp_hit2 = wb_wrenable & (byp_a2 == a3_q);
  assign byp_data = wr_q;
`endif

endmodule
